dct2d_8x8_core: RTL and testbench

//  Fully pipelined 8x8 two-dimensional DCT-II, Y = C * X * C^T, on signed Q16.16 fixed point.

---
 rtl/dct2d_8x8_core.sv | 128 ++++++++++++
 tb/tb_dct2d_8x8_core.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct2d_8x8_core.sv
// 8x8 2-D DCT-II, Y = C*X*C^T, Q16.16, two-stage pipeline.
// Stage 1 holds the row pass T, stage 2 holds the column pass Y.
module dct2d_8x8_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]   data_in_matrix,
  output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]   data_out_matrix
);

  logic [63:0][31:0] x;
  logic [63:0][31:0] t_d, t_q;
  logic [63:0][31:0] y_d, y_q;

  assign x = data_in_matrix;
  assign data_out_matrix = y_q;

  // C[k][n] in Q16.16; magnitudes are a(k)*cos(j*pi/16)
  // folded into the first quadrant.
  function automatic logic [31:0] coef(input int k, input int n);
    int m;
    int j;
    logic neg;
    logic [31:0] mag;
    m = ((2 * n + 1) * k) % 32;
    j = m;
    neg = 1'b0;
    if (m <= 8) begin
      j = m;
    end else if (m <= 16) begin
      j = 16 - m;
      neg = 1'b1;
    end else if (m <= 24) begin
      j = m - 16;
      neg = 1'b1;
    end else begin
      j = 32 - m;
    end
    case (j)
      0:       mag = 32'd32768;
      1:       mag = 32'd32138;
      2:       mag = 32'd30274;
      3:       mag = 32'd27246;
      4:       mag = 32'd23170;
      5:       mag = 32'd18205;
      6:       mag = 32'd12540;
      7:       mag = 32'd6393;
      default: mag = 32'd0;
    endcase
    if (k == 0) begin
      mag = 32'd23170;
      neg = 1'b0;
    end
    return neg ? (32'd0 - mag) : mag;
  endfunction

  // 8-term signed dot product, full precision, then
  // floor shift by 16 and wrap to 32 bits.
  function automatic logic [31:0] dot_rescale(
    input logic [7:0][31:0] a,
    input logic [7:0][31:0] b
  );
    logic signed [67:0] acc;
    logic signed [67:0] s;
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] p;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      ea = {{32{a[i][31]}}, a[i]};
      eb = {{32{b[i][31]}}, b[i]};
      p = ea * eb;
      acc = acc + {{4{p[63]}}, p};
    end
    s = acc >>> 16;
    return s[31:0];
  endfunction

  // Row pass: T[r][k] = sum_n X[r][n]*C[k][n]
  always_comb begin
    logic [7:0][31:0] va;
    logic [7:0][31:0] vb;
    t_d = '0;
    va = '0;
    vb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        for (int n = 0; n < 8; n++) begin
          va[n] = x[r*8+n];
          vb[n] = coef(k, n);
        end
        t_d[r*8+k] = dot_rescale(va, vb);
      end
    end
  end

  // Column pass: Y[k][c] = sum_r C[k][r]*T[r][c]
  always_comb begin
    logic [7:0][31:0] va;
    logic [7:0][31:0] vb;
    y_d = '0;
    va = '0;
    vb = '0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 8; c++) begin
        for (int r = 0; r < 8; r++) begin
          va[r] = coef(k, r);
          vb[r] = t_q[r*8+c];
        end
        y_d[k*8+c] = dot_rescale(va, vb);
      end
    end
  end

  // Pipeline registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_q <= '0;
      y_q <= '0;
    end else begin
      t_q <= t_d;
      y_q <= y_d;
    end
  end

endmodule

// File: tb/tb_dct2d_8x8_core.sv
// Bench for dct2d_8x8_core against a real-valued
// coefficient model with the two-pass truncation rule.
module tb_dct2d_8x8_core;

  logic          clk;
  logic          reset_n;
  logic [2047:0] din;
  logic [2047:0] dout;

  int passed;
  int total;
  int cm[8][8];

  dct2d_8x8_core dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .data_in_matrix  (din),
    .data_out_matrix (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic build_coefs();
    real pi;
    real a;
    real v;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        a = (k == 0) ? $sqrt(0.125) : 0.5;
        v = a * $cos((2.0 * n + 1.0) * k * pi / 16.0) * 65536.0;
        if (v >= 0.0) cm[k][n] = $rtoi(v + 0.5);
        else cm[k][n] = -$rtoi(-v + 0.5);
      end
    end
  endtask

  function automatic logic [2047:0] dct_ref(input logic [2047:0] xin);
    longint acc;
    int t[8][8];
    logic [2047:0] y;
    y = '0;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++)
          acc += longint'($signed(xin[(r*8+n)*32 +: 32])) * cm[k][n];
        t[r][k] = int'(acc >>> 16);
      end
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++) begin
        acc = 0;
        for (int r = 0; r < 8; r++)
          acc += longint'(cm[k][r]) * t[r][c];
        y[(k*8+c)*32 +: 32] = int'(acc >>> 16);
      end
    return y;
  endfunction

  function automatic logic [2047:0] rand_block();
    logic [2047:0] b;
    int v;
    for (int i = 0; i < 64; i++) begin
      v = int'($urandom_range(33423360, 0)) - 16711680;
      b[i*32 +: 32] = v;
    end
    return b;
  endfunction

  function automatic logic [2047:0] fill_block(input logic [31:0] v);
    logic [2047:0] b;
    for (int i = 0; i < 64; i++) b[i*32 +: 32] = v;
    return b;
  endfunction

  task automatic test_reset();
    logic [2047:0] blk;
    logic [2047:0] exp;
    reset_n = 1'b0;
    din = rand_block();
    repeat (3) begin
      @(negedge clk);
      total++;
      if (dout !== '0)
        $display("FAIL reset_hold got=%h exp=0", dout[31:0]);
      else passed++;
      din = rand_block();
    end
    blk = rand_block();
    exp = dct_ref(blk);
    @(negedge clk);
    din = blk;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) begin
      total++;
      if (dout[i*32 +: 32] !== exp[i*32 +: 32])
        $display("FAIL reset_release idx=%0d got=%h exp=%h",
                 i, dout[i*32 +: 32], exp[i*32 +: 32]);
      else passed++;
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) begin
      total++;
      if (dout[i*32 +: 32] !== 32'h0)
        $display("FAIL zero idx=%0d got=%h exp=00000000",
                 i, dout[i*32 +: 32]);
      else passed++;
    end
  endtask

  task automatic test_ones();
    logic [31:0] e;
    @(negedge clk);
    din = fill_block(32'h0001_0000);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) begin
      e = (i == 0) ? 32'h0007_FFEA : 32'h0;
      total++;
      if (dout[i*32 +: 32] !== e)
        $display("FAIL ones idx=%0d got=%h exp=%h",
                 i, dout[i*32 +: 32], e);
      else passed++;
    end
  endtask

  task automatic test_impulse();
    logic [2047:0] blk;
    logic [31:0] e;
    blk = '0;
    blk[31:0] = 32'h0001_0000;
    @(negedge clk);
    din = blk;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dout[31:0] !== 32'h0000_1FFF)
      $display("FAIL impulse_dc got=%h exp=00001fff", dout[31:0]);
    else passed++;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++) begin
        e = int'((longint'(cm[k][0]) * cm[c][0]) >>> 16);
        total++;
        if (dout[(k*8+c)*32 +: 32] !== e)
          $display("FAIL impulse idx=%0d got=%h exp=%h",
                   k*8+c, dout[(k*8+c)*32 +: 32], e);
        else passed++;
      end
  endtask

  task automatic test_random();
    logic [2047:0] blk;
    logic [2047:0] exp;
    for (int b = 0; b < 5; b++) begin
      blk = rand_block();
      exp = dct_ref(blk);
      @(negedge clk);
      din = blk;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 64; i++) begin
        total++;
        if (dout[i*32 +: 32] !== exp[i*32 +: 32])
          $display("FAIL random blk=%0d idx=%0d got=%h exp=%h",
                   b, i, dout[i*32 +: 32], exp[i*32 +: 32]);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2047:0] exp_q[$];
    logic [2047:0] blk;
    logic [2047:0] exp;
    for (int s = 0; s < 102; s++) begin
      @(negedge clk);
      if (s >= 2) begin
        exp = exp_q.pop_front();
        for (int i = 0; i < 64; i++) begin
          total++;
          if (dout[i*32 +: 32] !== exp[i*32 +: 32])
            $display("FAIL b2b step=%0d idx=%0d got=%h exp=%h",
                     s, i, dout[i*32 +: 32], exp[i*32 +: 32]);
          else passed++;
        end
      end
      if (s < 100) begin
        blk = rand_block();
        exp_q.push_back(dct_ref(blk));
        din = blk;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2047:0] blk;
    logic [2047:0] exp;
    @(negedge clk);
    din = rand_block();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (dout !== '0)
      $display("FAIL async_clear got=%h exp=0", dout[31:0]);
    else passed++;
    repeat (2) begin
      @(negedge clk);
      din = rand_block();
      total++;
      if (dout !== '0)
        $display("FAIL async_hold got=%h exp=0", dout[31:0]);
      else passed++;
    end
    blk = rand_block();
    exp = dct_ref(blk);
    @(negedge clk);
    din = blk;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (dout !== '0)
      $display("FAIL async_first_edge got=%h exp=0", dout[31:0]);
    else passed++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) begin
      total++;
      if (dout[i*32 +: 32] !== exp[i*32 +: 32])
        $display("FAIL async_second_edge idx=%0d got=%h exp=%h",
                 i, dout[i*32 +: 32], exp[i*32 +: 32]);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset_n = 1'b0;
    din = '0;
    build_coefs();
    test_reset();
    test_zero();
    test_ones();
    test_impulse();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
